// File: rtl/mul_unit.sv
// Iterative radix-2 shift-add RV32M multiply unit feeding the CDB.
// One op in flight; stalls issue until the result is broadcast or flushed.
module mul_unit #(
    parameter int DATA_WIDTH   = 32,
    parameter int TAG_WIDTH    = 6,
    parameter int OPCODE_WIDTH = 4,
    parameter int ADDR_WIDTH   = 32
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    i_flush,
    input  logic                    i_fu_valid,
    input  logic [OPCODE_WIDTH-1:0] i_fu_opcode,
    input  logic [ADDR_WIDTH-1:0]   i_fu_iaddr,
    input  logic [DATA_WIDTH-1:0]   i_fu_insn,
    input  logic [DATA_WIDTH-1:0]   i_fu_src_a,
    input  logic [DATA_WIDTH-1:0]   i_fu_src_b,
    input  logic [TAG_WIDTH-1:0]    i_fu_tag,
    output logic                    o_fu_stall,
    output logic                    o_cdb_req,
    output logic [DATA_WIDTH-1:0]   o_cdb_data,
    output logic [TAG_WIDTH-1:0]    o_cdb_tag,
    input  logic                    i_cdb_grant
);

    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = $clog2(W);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [TAG_WIDTH-1:0] tag_q;
    logic [1:0]         sel_q;
    logic               neg_q;
    logic [W-1:0]       mcand_q;
    logic [2*W-1:0]     prod_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [W-1:0]       result_q;

    logic [1:0]         sel;
    logic               a_sgn;
    logic               b_sgn;
    logic               a_neg;
    logic               b_neg;
    logic [W-1:0]       mag_a;
    logic [W-1:0]       mag_b;
    logic               accept;
    logic               last;
    logic [W:0]         sum;
    logic [2*W-1:0]     step;
    logic [2*W-1:0]     final_prod;
    logic [W-1:0]       final_res;

    assign sel   = i_fu_insn[13:12];
    assign a_sgn = (sel == 2'b01) || (sel == 2'b10);
    assign b_sgn = (sel == 2'b01);
    assign a_neg = a_sgn & i_fu_src_a[W-1];
    assign b_neg = b_sgn & i_fu_src_b[W-1];
    assign mag_a = a_neg ? (~i_fu_src_a + 1'b1) : i_fu_src_a;
    assign mag_b = b_neg ? (~i_fu_src_b + 1'b1) : i_fu_src_b;

    assign accept = (state_q == IDLE) & i_fu_valid & ~i_flush;
    assign last   = (cnt_q == CNT_W'(W - 1));

    // One shift-add step: carry out of the upper add becomes the new MSB.
    assign sum  = {1'b0, prod_q[2*W-1:W]}
                + (prod_q[0] ? {1'b0, mcand_q} : {(W+1){1'b0}});
    assign step = {sum, prod_q[W-1:1]};

    assign final_prod = neg_q ? (~step + 1'b1) : step;
    assign final_res  = (sel_q == 2'b00) ? final_prod[W-1:0]
                                         : final_prod[2*W-1:W];

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (i_fu_valid)  state_d = BUSY;
            BUSY:    if (last)        state_d = DONE;
            DONE:    if (i_cdb_grant) state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
        if (i_flush) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            tag_q    <= '0;
            sel_q    <= '0;
            neg_q    <= 1'b0;
            mcand_q  <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else if (accept) begin
            tag_q   <= i_fu_tag;
            sel_q   <= sel;
            neg_q   <= a_neg ^ b_neg;
            mcand_q <= mag_a;
            prod_q  <= {{W{1'b0}}, mag_b};
            cnt_q   <= '0;
        end else if (state_q == BUSY && !i_flush) begin
            prod_q <= step;
            cnt_q  <= cnt_q + 1'b1;
            if (last) begin
                result_q <= final_res;
            end
        end
    end

    assign o_fu_stall = (state_q != IDLE);
    assign o_cdb_req  = (state_q == DONE);
    assign o_cdb_data = result_q;
    assign o_cdb_tag  = tag_q;

    logic unused_inputs;
    assign unused_inputs = ^{i_fu_opcode, i_fu_iaddr,
                             i_fu_insn[W-1:14], i_fu_insn[11:0]};

`ifndef SYNTHESIS
    issue_while_stalled: assert property (
        @(posedge clk) disable iff (!n_rst)
        i_fu_valid |-> !o_fu_stall
    );
`endif

endmodule
